// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA stream movers (mm2s / s2mm).
package dma_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    DRAIN  = 2'd3
  } mm2s_state_t;

  localparam int PS_IDX_W  = 4;
  localparam int PS_DATA_W = 32;

  localparam logic [PS_IDX_W-1:0] REG_SRC_ADDR = 4'd0;
  localparam logic [PS_IDX_W-1:0] REG_LENGTH   = 4'd1;
  localparam logic [PS_IDX_W-1:0] REG_CTRL     = 4'd2;
  localparam logic [PS_IDX_W-1:0] REG_STATUS   = 4'd3;

  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_DONE  = 1;
  localparam int STATUS_ERROR = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_if.sv
// AXI4-lite bundle (all five channels).
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  modport master (output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                  input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
  modport slave  (input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                  output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
endinterface

// File: rtl/axi_stream_if.sv
// AXI-stream bundle with data/valid/ready/last.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;
  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/ps_if.sv
// PS register-access bundle: single-cycle writes with a delayed response, combinational reads.
interface ps_if;
  import dma_pkg::*;
  logic [PS_IDX_W-1:0]  waddr;
  logic [PS_DATA_W-1:0] wdata;
  logic                 wvalid;
  logic                 wready;
  logic                 wresp;
  logic [PS_IDX_W-1:0]  raddr;
  logic                 arvalid;
  logic [PS_DATA_W-1:0] rdata;
  logic                 rvalid;
  modport slave  (input waddr, wdata, wvalid, raddr, arvalid,
                  output wready, wresp, rdata, rvalid);
  modport master (output waddr, wdata, wvalid, raddr, arvalid,
                  input wready, wresp, rdata, rvalid);
endinterface

// File: rtl/mm2s_fifo.sv
// Small synchronous FIFO buffering read data (with its last flag) ahead of the stream port.
module mm2s_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/mm2s.sv
// Memory-mapped-to-stream reader: single-word AXI-lite reads into a FIFO, emitted as one stream frame.
module mm2s
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ps_if.slave          ps_i,
  axi_lite_if.master   mem_i,
  axi_stream_if.master dout_i
);
  localparam int ADDR_WIDTH = $bits(mem_i.araddr);
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SH    = $clog2(BYTES);
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PS_DATA_W-1:0] BYTE_MASK = PS_DATA_W'(BYTES - 1);

  mm2s_state_t           state_q, state_d;
  logic [PS_DATA_W-1:0]  src_addr_q, src_addr_d, length_q, length_d;
  logic [PS_DATA_W-1:0]  words_left_q, words_left_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic done_q, done_d, error_q, error_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, wresp_q, wresp_d;

  logic                  push, pop, ar_hs, resp_bad, last_beat, busy, start_req, cfg_ok;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count, count_nxt;
  logic [DATA_WIDTH:0]   fifo_din, fifo_dout;
  logic [PS_DATA_W-1:0]  ps_rdata;
  logic                  unused_ok;

  mm2s_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign push      = rready_q && mem_i.rvalid;
  assign ar_hs     = arvalid_q && mem_i.arready;
  assign resp_bad  = (mem_i.rresp != RESP_OKAY);
  assign last_beat = resp_bad || (words_left_q == 32'd1);
  assign fifo_din  = {last_beat, mem_i.rdata};
  assign pop       = !fifo_empty && dout_i.ready;
  // Occupancy as it will be after this edge; used to keep a slot reserved for the next read.
  assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign busy      = (state_q != IDLE);
  assign start_req = ps_i.wvalid && (ps_i.waddr == REG_CTRL) && ps_i.wdata[0];
  assign cfg_ok    = (length_q != '0) && ((length_q & BYTE_MASK) == '0) &&
                     ((src_addr_q & BYTE_MASK) == '0);

  // Register writes, start checks and the read/drain sequencing.
  always_comb begin
    state_d      = state_q;
    src_addr_d   = src_addr_q;
    length_d     = length_q;
    words_left_d = words_left_q;
    rd_addr_d    = rd_addr_q;
    done_d       = done_q;
    error_d      = error_q;
    wresp_d      = ps_i.wvalid;
    if (ps_i.wvalid && !busy) begin
      if (ps_i.waddr == REG_SRC_ADDR) src_addr_d = ps_i.wdata;
      if (ps_i.waddr == REG_LENGTH)   length_d   = ps_i.wdata;
    end
    case (state_q)
      IDLE: begin
        if (start_req) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          if (cfg_ok) begin
            rd_addr_d    = ADDR_WIDTH'(src_addr_q);
            words_left_d = length_q >> BYTE_SH;
            state_d      = ISSUE;
          end else begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      ISSUE: if (ar_hs) state_d = WAIT_R;
      WAIT_R: begin
        if (push) begin
          words_left_d = words_left_q - 32'd1;
          rd_addr_d    = rd_addr_q + ADDR_WIDTH'(BYTES);
          if (resp_bad) begin
            error_d      = 1'b1;
            words_left_d = '0;
          end
          state_d = last_beat ? DRAIN : ISSUE;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    arvalid_d = (state_d == ISSUE) && (count_nxt < CNT_W'(FIFO_DEPTH));
    rready_d  = (state_d == WAIT_R);
  end

  // Control and bus-handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_addr_q   <= '0;
      length_q     <= '0;
      words_left_q <= '0;
      rd_addr_q    <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      wresp_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_addr_q   <= src_addr_d;
      length_q     <= length_d;
      words_left_q <= words_left_d;
      rd_addr_q    <= rd_addr_d;
      done_q       <= done_d;
      error_q      <= error_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      wresp_q      <= wresp_d;
    end
  end

  // PS read mux; CTRL and unmapped indices read as zero.
  always_comb begin
    ps_rdata = '0;
    case (ps_i.raddr)
      REG_SRC_ADDR: ps_rdata = src_addr_q;
      REG_LENGTH:   ps_rdata = length_q;
      REG_STATUS: begin
        ps_rdata[STATUS_BUSY]  = busy;
        ps_rdata[STATUS_DONE]  = done_q;
        ps_rdata[STATUS_ERROR] = error_q;
      end
      default: ps_rdata = '0;
    endcase
  end

  assign ps_i.wready   = 1'b1;
  assign ps_i.wresp    = wresp_q;
  assign ps_i.rvalid   = ps_i.arvalid;
  assign ps_i.rdata    = ps_rdata;

  assign mem_i.araddr  = rd_addr_q;
  assign mem_i.arvalid = arvalid_q;
  assign mem_i.rready  = rready_q;
  assign mem_i.awaddr  = '0;
  assign mem_i.awvalid = 1'b0;
  assign mem_i.wdata   = '0;
  assign mem_i.wstrb   = '0;
  assign mem_i.wvalid  = 1'b0;
  assign mem_i.bready  = 1'b0;

  assign dout_i.valid  = !fifo_empty;
  assign dout_i.data   = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign dout_i.last   = !fifo_empty && fifo_dout[DATA_WIDTH];

  assign unused_ok = ^{mem_i.awready, mem_i.wready, mem_i.bresp, mem_i.bvalid, fifo_full};
endmodule

// File: tb/tb_mm2s.sv
// Randomized scoreboard bench for mm2s: memory responder, stream sink and a frame-level reference model.
module tb_mm2s;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps_if ps ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem ();
  axi_stream_if #(.DATA_WIDTH(32)) dout ();

  mm2s #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ps_i   (ps.slave),
    .mem_i  (mem.master),
    .dout_i (dout.master)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_addr_q[$];
  logic [32:0] exp_beat_q[$];
  int ar_cnt = 0;
  int beat_cnt = 0;
  bit err_en = 1'b0;
  logic [31:0] err_addr = '0;
  int lat_max = 0;
  int rdy_mode = 2;  // 0: hold ready low, 1: random ready, 2: ready high

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return 32'hA0 + ((a - 32'h100) >> 2);
  endfunction

  // Memory slave: random arready/rvalid latency; handshakes decided at one negedge complete at the next posedge.
  initial begin
    bit ar_hs_p, r_hs_p, pend;
    int ad, rd;
    logic [31:0] paddr;
    ar_hs_p = 0; r_hs_p = 0; pend = 0; ad = 0; rd = 0; paddr = '0;
    mem.arready = 0; mem.rvalid = 0; mem.rdata = '0; mem.rresp = RESP_OKAY;
    mem.awready = 0; mem.wready = 0; mem.bvalid = 0; mem.bresp = RESP_OKAY;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_hs_p = 0; r_hs_p = 0; pend = 0; ad = 0;
        mem.arready = 0; mem.rvalid = 0;
        continue;
      end
      if (ar_hs_p) begin
        mem.arready = 0;
        pend = 1;
        rd = $urandom_range(0, lat_max);
        ad = $urandom_range(0, lat_max);
        ar_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL araddr_extra: got 0x%0h expected no read", paddr);
        end else check("araddr", paddr, exp_addr_q.pop_front());
      end
      if (r_hs_p) begin
        mem.rvalid = 0;
        pend = 0;
      end
      if (!pend && mem.arvalid && !mem.arready) begin
        if (ad == 0) begin
          mem.arready = 1;
          paddr = mem.araddr;
        end else ad--;
      end
      if (pend && !mem.rvalid) begin
        if (rd == 0) begin
          mem.rvalid = 1;
          mem.rdata  = mem_word(paddr);
          mem.rresp  = (err_en && paddr == err_addr) ? RESP_SLVERR : RESP_OKAY;
        end else rd--;
      end
      ar_hs_p = mem.arvalid && mem.arready;
      r_hs_p  = mem.rvalid && mem.rready;
    end
  end

  // Stream sink and scoreboard monitor: pops one expected beat per accepted beat, checks stall stability.
  initial begin
    bit hs_p, stall_p;
    logic [32:0] beat_p, stall_beat;
    hs_p = 0; stall_p = 0; beat_p = '0; stall_beat = '0;
    dout.ready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_p = 0; stall_p = 0; dout.ready = 0;
        continue;
      end
      if (hs_p) begin
        beat_cnt++;
        if (exp_beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_extra: got 0x%0h expected no beat", beat_p);
        end else check("beat", beat_p, exp_beat_q.pop_front());
      end
      if (stall_p) check("stall_stable", {dout.valid, dout.last, dout.data}, {1'b1, stall_beat});
      case (rdy_mode)
        0: dout.ready = 0;
        1: dout.ready = 1'($urandom_range(0, 1));
        default: dout.ready = 1;
      endcase
      beat_p     = {dout.last, dout.data};
      hs_p       = dout.valid && dout.ready;
      stall_p    = dout.valid && !dout.ready;
      stall_beat = beat_p;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ps_write(logic [3:0] idx, logic [31:0] data);
    @(negedge clk);
    ps.waddr = idx; ps.wdata = data; ps.wvalid = 1;
    #1 check("wready", ps.wready, 1);
    @(negedge clk);
    check("wresp", ps.wresp, 1);
    ps.wvalid = 0;
  endtask

  task automatic ps_read(logic [3:0] idx, output logic [31:0] data);
    ps.raddr = idx; ps.arvalid = 1;
    #1 data = ps.rdata;
    ps.arvalid = 0;
  endtask

  task automatic check_reg(string name, logic [3:0] idx, logic [31:0] exp);
    logic [31:0] v;
    ps.raddr = idx; ps.arvalid = 1;
    #1 check({name, "_rvalid"}, ps.rvalid, 1);
    v = ps.rdata;
    ps.arvalid = 0;
    check(name, v, exp);
  endtask

  // Reference model: the frame a transfer must produce, derived from the register values alone.
  task automatic model_transfer(logic [31:0] src, logic [31:0] len, output logic [31:0] status);
    int n;
    logic [31:0] a;
    bit bad;
    if (len == 0 || len % 4 != 0 || src % 4 != 0) begin
      status = 32'h6;
      return;
    end
    n = int'(len / 4);
    status = 32'h2;
    for (int i = 0; i < n; i++) begin
      a = src + 32'(4 * i);
      bad = err_en && (a == err_addr);
      exp_addr_q.push_back(a);
      exp_beat_q.push_back({(i == n - 1) || bad, mem_word(a)});
      if (bad) begin
        status = 32'h6;
        break;
      end
    end
  endtask

  task automatic wait_idle(string name);
    logic [31:0] s;
    int n;
    n = 0;
    ps_read(REG_STATUS, s);
    while (s[STATUS_BUSY] && n < 3000) begin
      @(negedge clk);
      ps_read(REG_STATUS, s);
      n++;
    end
    if (s[STATUS_BUSY]) begin
      checks++; errors++;
      $display("FAIL %s_timeout: busy=%0d after %0d cycles, required 0", name, s[STATUS_BUSY], n);
    end
  endtask

  task automatic run_transfer(string name, logic [31:0] src, logic [31:0] len, int exp_reads);
    logic [31:0] st;
    int c0;
    ps_write(REG_SRC_ADDR, src);
    ps_write(REG_LENGTH, len);
    model_transfer(src, len, st);
    c0 = ar_cnt;
    ps_write(REG_CTRL, 32'h1);
    wait_idle(name);
    repeat (2) @(negedge clk);
    check_reg({name, "_status"}, REG_STATUS, st);
    check({name, "_addr_left"}, exp_addr_q.size(), 0);
    check({name, "_beat_left"}, exp_beat_q.size(), 0);
    if (exp_reads >= 0) check({name, "_reads"}, ar_cnt - c0, exp_reads);
    exp_addr_q.delete();
    exp_beat_q.delete();
  endtask

  initial begin
    logic [31:0] src, len, st;
    int c0, b0, n;
    ps.waddr = '0; ps.wdata = '0; ps.wvalid = 0; ps.raddr = '0; ps.arvalid = 0;

    // Reset state
    #2;
    check("rst_arvalid", mem.arvalid, 0);
    check("rst_rready", mem.rready, 0);
    check("rst_valid", dout.valid, 0);
    check("rst_last", dout.last, 0);
    check("rst_wresp", ps.wresp, 0);
    check("wr_chan_tied", {mem.awvalid, mem.wvalid, mem.bready}, 0);
    check("wr_data_tied", mem.awaddr | mem.wdata | {28'b0, mem.wstrb}, 0);
    check_reg("rst_status", REG_STATUS, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Basic frame
    lat_max = 0; rdy_mode = 2;
    run_transfer("basic", 32'h100, 32'd16, 4);
    check_reg("unmapped_read", 4'd9, 32'h0);
    check_reg("length_read", REG_LENGTH, 32'd16);

    // Bad configurations
    run_transfer("len0", 32'h100, 32'd0, 0);
    run_transfer("len6", 32'h100, 32'd6, 0);
    run_transfer("src_unaligned", 32'h102, 32'd16, 0);

    // Backpressure: FIFO fills, read issue stops
    lat_max = 0; rdy_mode = 0;
    ps_write(REG_SRC_ADDR, 32'h300);
    ps_write(REG_LENGTH, 32'd32);
    model_transfer(32'h300, 32'd32, st);
    c0 = ar_cnt; b0 = beat_cnt;
    ps_write(REG_CTRL, 32'h1);
    repeat (20) @(negedge clk);
    check("bp_reads", ar_cnt - c0, 4);
    check("bp_arvalid", mem.arvalid, 0);
    check("bp_beats", beat_cnt - b0, 0);
    rdy_mode = 2;
    wait_idle("bp");
    repeat (2) @(negedge clk);
    check_reg("bp_status", REG_STATUS, st);
    check("bp_beat_left", exp_beat_q.size(), 0);
    check("bp_total_beats", beat_cnt - b0, 8);

    // Slave error on the second read
    err_en = 1; err_addr = 32'h404;
    run_transfer("slverr", 32'h400, 32'd16, 2);
    err_en = 0;

    // Busy guard
    lat_max = 1; rdy_mode = 1;
    ps_write(REG_SRC_ADDR, 32'h600);
    ps_write(REG_LENGTH, 32'd32);
    model_transfer(32'h600, 32'd32, st);
    ps_write(REG_CTRL, 32'h1);
    check_reg("busy_status", REG_STATUS, 32'h1);
    ps_write(REG_SRC_ADDR, 32'h500);
    ps_write(REG_CTRL, 32'h1);
    check_reg("busy_src_kept", REG_SRC_ADDR, 32'h600);
    wait_idle("busy");
    repeat (2) @(negedge clk);
    check_reg("busy_done_status", REG_STATUS, st);
    check("busy_beat_left", exp_beat_q.size(), 0);
    exp_addr_q.delete(); exp_beat_q.delete();

    // Reset mid-transfer
    lat_max = 0; rdy_mode = 2;
    ps_write(REG_SRC_ADDR, 32'h700);
    ps_write(REG_LENGTH, 32'd32);
    model_transfer(32'h700, 32'd32, st);
    b0 = beat_cnt;
    ps_write(REG_CTRL, 32'h1);
    n = 0;
    while (beat_cnt - b0 < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_two_beats", beat_cnt - b0, 2);
    #1 rst_n = 0;
    #1;
    check("mid_rst_arvalid", mem.arvalid, 0);
    check("mid_rst_rready", mem.rready, 0);
    check("mid_rst_valid", dout.valid, 0);
    check("mid_rst_last", dout.last, 0);
    check("mid_rst_wresp", ps.wresp, 0);
    exp_addr_q.delete(); exp_beat_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    b0 = beat_cnt;
    repeat (5) @(negedge clk);
    check("post_rst_valid", dout.valid, 0);
    check("post_rst_beats", beat_cnt - b0, 0);
    check_reg("post_rst_status", REG_STATUS, 32'h0);
    check_reg("post_rst_src", REG_SRC_ADDR, 32'h0);
    run_transfer("post_rst", 32'h800, 32'd12, 3);

    // Address wrap at the top of the address space
    run_transfer("wrap", 32'hFFFF_FFF8, 32'd16, 4);

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      lat_max  = $urandom_range(0, 2);
      rdy_mode = $urandom_range(1, 2);
      src = $urandom & 32'hFFFF_FFFC;
      len = 32'(4 * $urandom_range(1, 10));
      if ($urandom_range(0, 5) == 0) len = len + 32'd2;
      err_en = ($urandom_range(0, 2) == 0);
      err_addr = src + 32'(4 * $urandom_range(0, 9));
      run_transfer("rand", src, len, -1);
      err_en = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mm2s.md
Name: mm2s

Overview:
- Memory-mapped-to-stream DMA reader, the source-side counterpart of the s2mm writer.
- The PS programs a source byte address and a byte length, then writes START.
- The block issues single-word AXI-lite reads, buffers the returned words in a small FIFO, and emits them as an AXI-stream frame with last on the final word.
- It sits upstream of the processing pipeline that terminates in s2mm.

Parameters:
- DATA_WIDTH, 32, width of the stream data and AXI-lite data; byte address increment per beat is DATA_WIDTH/8.
- FIFO_DEPTH, 4, output buffer depth in words; power of two, minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ps_i  ps_if.slave  bundle  PS register access (waddr/wdata/wvalid/wready/wresp, raddr/arvalid/rdata/rvalid)
- mem_i  axi_lite_if.master  bundle  memory read master (araddr/arvalid/arready, rdata/rresp/rvalid/rready); write channels tied inactive
- dout_i  axi_stream_if.master  bundle  output stream (data/valid/ready/last)

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. While rst_n is low:
  - state=IDLE and all registers are 0.
  - mem_i.arvalid=0, mem_i.rready=0, dout_i.valid=0, dout_i.last=0, FIFO empty, ps_i.wresp=0.
- Reset mid-transfer discards the FIFO contents and any outstanding read; no stream beat follows reset release.
- PS register map (word index), ADDR: 0 = SRC_ADDR, 1 = LENGTH in bytes, 2 = CTRL (write bit0=1 -> start), 3 = STATUS (bit0 busy, bit1 done, bit2 error).
- PS writes: wready=1 always; wresp is asserted 1 cycle after wvalid.
  - Writes to 0/1 are ignored while busy.
  - Writes to 3, and writes to unmapped indices, are ignored.
- PS reads: combinational. rvalid=arvalid; rdata = register at raddr; unmapped index returns 0.
- Start (CTRL bit0 while IDLE):
  - Clears done and error.
  - Checks LENGTH!=0, LENGTH a multiple of DATA_WIDTH/8, SRC_ADDR word-aligned.
  - On check failure: error=1, done=1, stay IDLE, no bus or stream activity.
  - On success: load rd_addr=SRC_ADDR and words_left=LENGTH/(DATA_WIDTH/8), go to ISSUE.
  - Start while busy is ignored.
- States:
  - IDLE: busy=0.
  - ISSUE: hold arvalid=1 and araddr=rd_addr, but only when the FIFO has at least one free slot not reserved by an outstanding read. On arready, go to WAIT_R.
  - WAIT_R: rready=1. On rvalid, push rdata to the FIFO with last=(words_left==1), decrement words_left, and add DATA_WIDTH/8 to rd_addr. If words_left becomes 0 go to DRAIN, else go to ISSUE.
  - DRAIN: wait until the FIFO is empty and the final beat has been accepted, then set done=1 and go to IDLE.
- At most one outstanding read (AXI-lite); arvalid and araddr stay stable until arready.
- rresp!=OKAY:
  - Set error=1.
  - Push that beat with last=1, cancel the remaining reads, go to DRAIN.
  - done is still set at the end of DRAIN.
- Address arithmetic: addresses wrap modulo 2^ADDR_WIDTH with no error. ADDR_WIDTH is taken from mem_i.
- Stream output:
  - dout_i.valid = FIFO not empty; data and last come from the FIFO head.
  - A pop happens only when valid&&ready.
  - valid, data and last stay stable while ready=0.
- Simultaneous FIFO push and pop on a full FIFO: not possible, because a read is issued only with a reserved slot. Push and pop in the same cycle otherwise leave the count unchanged.
- Latency: the first dout_i.valid appears 1 cycle after the first mem_i rvalid handshake. Full throughput is 1 word per 2 cycles, limited by AXI-lite with zero-latency memory.

Decomposition:
- Shared package dma_pkg holds:
  - the mm2s_state_t enum {IDLE, ISSUE, WAIT_R, DRAIN};
  - register-index constants (REG_SRC_ADDR, REG_LENGTH, REG_CTRL, REG_STATUS);
  - STATUS bit positions;
  - AXI resp constant RESP_OKAY.
- One sub-module: mm2s_fifo, a synchronous FIFO.
  - Parameters: DATA_WIDTH+1 width, FIFO_DEPTH.
  - Ports: push/pop/full/empty/count, async active-low reset.

Test Plan:
- Basic: SRC_ADDR=0x100, LENGTH=16, start, memory returns 0xA0..0xA3, ready=1 -> araddr sequence 0x100, 0x104, 0x108, 0x10C; 4 beats 0xA0..0xA3 with last only on 0xA3; STATUS=0x2.
- Backpressure: LENGTH=32, dout_i.ready=0 for 20 cycles -> exactly 4 reads issued, then arvalid stays 0; after ready=1 all 8 beats arrive in order, data stable while stalled.
- Bad config:
  - LENGTH=0 -> STATUS=0x6, no arvalid.
  - LENGTH=6 -> STATUS=0x6.
  - SRC_ADDR=0x102 -> STATUS=0x6.
- Slave error: LENGTH=16, rresp=SLVERR on the 2nd read -> 2 beats, last on the 2nd, no 3rd araddr, STATUS=0x6.
- Busy guard: during a transfer, write SRC_ADDR=0x500 and CTRL=1 -> ignored; the transfer completes from the original address; STATUS reads 0x1 while running.
- Reset mid-transfer: assert rst_n=0 after the 2nd beat of 8 -> outputs zero immediately (async); after release, valid=0 and STATUS=0; a new start works normally.
